// File: rtl/sram_stream_reader.sv
// sram_stream_reader: issues sequential reads to a synchronous single-port
// SRAM and streams the returned words out through a small credit-limited FIFO.
module sram_stream_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BITWIDTH   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [BITWIDTH-1:0]   sram_data,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic                  sram_oe,
    output logic [BITWIDTH-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                state;
    state_t                next_state;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      issue_cnt;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic [BITWIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic [CNT_W:0]        occupancy;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  push;
    logic                  pop;
    logic                  last_pop;

    // The block only ever listens on the SRAM data bus.
    assign sram_data = 'z;

    // Words buffered plus the one possibly in flight form the credit window.
    assign occupancy  = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
    assign issue      = (state == ST_READ) && (issue_cnt < len_q)
                        && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign issue_addr = base_q + issue_cnt[ADDR_WIDTH-1:0];
    assign push       = inflight;
    assign pop        = out_valid & out_ready;
    assign last_pop   = (fifo_count == CNT_W'(1)) && pop;

    assign sram_addr  = issue ? issue_addr : addr_q;
    assign sram_cs    = issue | inflight;
    assign sram_oe    = sram_cs;
    assign sram_we    = 1'b0;
    assign out_data   = fifo_mem[rd_ptr];
    assign out_valid  = (fifo_count != '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status outputs; DRAIN looks one pop ahead so done lands
    // in the cycle right after the final handshake.
    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = (length == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (issue && ((issue_cnt + LEN_W'(1)) == len_q)) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight && ((fifo_count == '0) || last_pop)) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Command latch, issue counter, held address and in-flight flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            inflight  <= 1'b0;
            addr_q    <= '0;
        end else begin
            inflight <= issue;
            if (state == ST_IDLE && start) begin
                base_q    <= base_addr;
                len_q     <= length;
                issue_cnt <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + LEN_W'(1);
                addr_q    <= issue_addr;
            end
        end
    end

    // Output FIFO: captures the SRAM word in the cycle after each issue and
    // releases its head on every downstream handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= sram_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Testbench for sram_stream_reader: directed bursts with a scoreboard queue
// and a negedge monitor that compares every stream handshake.
module tb_sram_stream_reader;

    localparam int AW    = 10;
    localparam int BW    = 16;
    localparam int DEPTH = 4;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] sram_addr;
    wire  [BW-1:0] sram_data;
    logic          sram_cs;
    logic          sram_we;
    logic          sram_oe;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    sram_stream_reader #(.ADDR_WIDTH(AW), .BITWIDTH(BW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_oe(sram_oe),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model: registers the addressed word, drives it next cycle.
    logic [BW-1:0] mem [MEMSZ];
    logic [BW-1:0] sram_rdata;
    initial begin
        for (int i = 0; i < MEMSZ; i++) mem[i] = BW'(i + 100);
        sram_rdata = '0;
    end
    always @(posedge clk) if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr];
    assign sram_data = (sram_cs && sram_oe) ? sram_rdata : 'z;

    int checks = 0;
    int fails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard and monitor model state.
    logic [BW-1:0] exp_q [$];
    int cycle = 0;
    int cur_base = 0, cur_len = 0, issued = 0;
    bit cmd_has_data = 0;
    int tb_fifo = 0;
    bit prev_issue = 0, prev_inflight = 0, prev_hs = 0, done_prev = 0;
    int last_hs_cycle = -10;
    int cs_viol = 0, pin_viol = 0, valid_viol = 0, credit_viol = 0, stall_cycles = 0;

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        bit inflight_now, cur_issue, hs;
        logic [AW-1:0] exp_addr;
        if (rst) begin
            tb_fifo = 0; prev_issue = 0; prev_inflight = 0; prev_hs = 0; done_prev = 0;
        end else begin
            inflight_now = prev_issue;
            tb_fifo      = tb_fifo + int'(prev_inflight) - int'(prev_hs);
            exp_addr     = AW'(cur_base + issued);
            cur_issue    = 0;
            if (sram_cs && issued < cur_len && sram_addr == exp_addr) begin
                cur_issue = 1;
                issued++;
            end
            if (sram_cs !== (cur_issue || inflight_now)) cs_viol++;
            if (sram_we !== 1'b0 || sram_oe !== sram_cs) pin_viol++;
            if (out_valid !== (tb_fifo != 0)) valid_viol++;
            if (tb_fifo + int'(inflight_now) > DEPTH) credit_viol++;
            if (busy && !sram_cs && issued < cur_len) stall_cycles++;
            hs = out_valid && out_ready;
            if (hs) begin
                if (exp_q.size() == 0) checkOutput("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                else checkOutput("stream_word", 32'(out_data), 32'(exp_q.pop_front()));
                last_hs_cycle = cycle;
            end
            if (done) begin
                if (cmd_has_data) checkOutput("done_after_last_hs", cycle, last_hs_cycle + 1);
                checkOutput("done_pulse_width", 32'(done_prev), 0);
                checkOutput("queue_empty_at_done", exp_q.size(), 0);
            end
            prev_issue    = cur_issue;
            prev_inflight = inflight_now;
            prev_hs       = hs;
            done_prev     = done;
        end
    end

    // Issue a start command and queue the words it should produce.
    task automatic applyStimulus(input int base, input int len);
        @(posedge clk); #1;
        for (int i = 0; i < len; i++) exp_q.push_back(BW'(((base + i) % MEMSZ) + 100));
        cur_base = base; cur_len = len; issued = 0; cmd_has_data = (len != 0);
        start = 1'b1; base_addr = AW'(base); length = (AW + 1)'(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, "_finished"}, 32'(busy), 0);
        checkOutput({name, "_all_words_seen"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] pat;
        pat = 4'b1001;
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        #1;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_cs", 32'(sram_cs), 0);
        checkOutput("reset_valid", 32'(out_valid), 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Basic burst with full throughput.
        applyStimulus(5, 4);
        checkOutput("t1_busy", 32'(busy), 1);
        checkOutput("t1_first_cs", 32'(sram_cs), 1);
        checkOutput("t1_first_addr", 32'(sram_addr), 5);
        checkOutput("t1_valid_T", 32'(out_valid), 0);
        @(posedge clk); #1;
        checkOutput("t1_valid_T1", 32'(out_valid), 0);
        @(posedge clk); #1;
        checkOutput("t1_valid_T2", 32'(out_valid), 1);
        checkOutput("t1_data_T2", 32'(out_data), 105);
        waitIdle("t1", 50);

        // Backpressure with a 1,0,0,1 ready pattern over a longer burst.
        stall_cycles = 0;
        applyStimulus(5, 10);
        for (int i = 0; i < 300 && busy; i++) begin
            out_ready = pat[i % 4];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        waitIdle("t2", 50);
        checkOutput("t2_credit_stall_seen", 32'(stall_cycles > 0), 1);

        // Address wrap past the top of the SRAM.
        applyStimulus(MEMSZ - 2, 4);
        checkOutput("t3_first_addr", 32'(sram_addr), MEMSZ - 2);
        waitIdle("t3", 50);

        // Zero-length command.
        applyStimulus(7, 0);
        checkOutput("t4_done", 32'(done), 1);
        checkOutput("t4_busy", 32'(busy), 1);
        checkOutput("t4_cs", 32'(sram_cs), 0);
        @(posedge clk); #1;
        checkOutput("t4_done_gone", 32'(done), 0);
        checkOutput("t4_idle", 32'(busy), 0);
        checkOutput("t4_valid", 32'(out_valid), 0);

        // Start pulsed mid-burst must be ignored.
        applyStimulus(20, 6);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(500); length = (AW + 1)'(3);
        @(posedge clk); #1;
        start = 1'b0;
        waitIdle("t5", 50);
        @(posedge clk); #1;
        checkOutput("t5_no_restart", 32'(busy), 0);

        // Full address space from a nonzero base.
        applyStimulus(3, MEMSZ);
        waitIdle("t6", 3000);

        // Asynchronous reset mid-burst under backpressure.
        out_ready = 1'b0;
        applyStimulus(40, 8);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("t7_rst_busy", 32'(busy), 0);
        checkOutput("t7_rst_done", 32'(done), 0);
        checkOutput("t7_rst_cs", 32'(sram_cs), 0);
        checkOutput("t7_rst_oe", 32'(sram_oe), 0);
        checkOutput("t7_rst_we", 32'(sram_we), 0);
        checkOutput("t7_rst_addr", 32'(sram_addr), 0);
        checkOutput("t7_rst_valid", 32'(out_valid), 0);
        checkOutput("t7_rst_data", 32'(out_data), 0);
        exp_q.delete();
        cur_len = 0; issued = 0;
        #3 rst = 1'b0;
        out_ready = 1'b1;
        applyStimulus(0, 2);
        waitIdle("t7", 50);

        checkOutput("cs_matches_model", cs_viol, 0);
        checkOutput("we_low_oe_eq_cs", pin_viol, 0);
        checkOutput("valid_matches_model", valid_viol, 0);
        checkOutput("credit_never_exceeded", credit_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
